// File: rtl/vend_pkg.sv
// Shared types and constants for the coin-accepting vending controller.
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACCUM    = 3'd1,
    DISPENSE = 3'd2,
    CHANGE   = 3'd3,
    REFUND   = 3'd4
  } state_t;

  localparam int COIN5_STEPS  = 1;
  localparam int COIN10_STEPS = 2;

endpackage

// File: rtl/vend_tick_counter.sv
// Counts divided-rate ticks while enabled; tc flags the tick that completes PULSE_TICKS.
module vend_tick_counter #(
  parameter int PULSE_TICKS = 4
) (
  input  logic clk_in,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = $clog2(PULSE_TICKS + 1);

  logic [CNT_W-1:0] cnt;

  // tc is combinational so the FSM can leave on the same edge that takes the last tick
  assign tc = en && (cnt == CNT_W'(PULSE_TICKS - 1));

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: coin credit, dispense pacing and change/refund payout.
// Define VEND_CHANGE_EN to pay out the post-dispense remainder; otherwise it stays as credit.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE       = 3,
  parameter int CREDIT_W    = 4,
  parameter int PULSE_TICKS = 4
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                tick_in,
  input  logic                coin5,
  input  logic                coin10,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic                change5,
  output logic                coin_reject,
  output logic                busy
);

  localparam int SUM_W = CREDIT_W + 1;
  localparam logic [SUM_W-1:0] MAX_CREDIT = {1'b0, {CREDIT_W{1'b1}}};
  localparam logic [SUM_W-1:0] PRICE_S    = SUM_W'(PRICE);

  state_t              state, state_d;
  logic [CREDIT_W-1:0] credit_d;
  logic                change5_d, reject_d;
  logic [1:0]          coin_val;
  logic [SUM_W-1:0]    sum;
  logic                coin_any, coin_fit;
  logic                cnt_clr, cnt_en, tc;

  assign coin_val = (coin5  ? 2'(COIN5_STEPS)  : 2'd0)
                  + (coin10 ? 2'(COIN10_STEPS) : 2'd0);
  assign sum      = {1'b0, credit} + SUM_W'(coin_val);
  assign coin_any = (coin_val != 2'd0);
  assign coin_fit = (sum <= MAX_CREDIT);

  // Holding the counter clear outside DISPENSE guarantees a fresh count on every entry
  assign cnt_clr = (state != DISPENSE);
  assign cnt_en  = tick_in && (state == DISPENSE);

  vend_tick_counter #(
    .PULSE_TICKS(PULSE_TICKS)
  ) u_tick_counter (
    .clk_in (clk_in),
    .rst    (rst),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .tc     (tc)
  );

  always_comb begin
    state_d   = state;
    credit_d  = credit;
    change5_d = 1'b0;
    reject_d  = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        if (coin_any && !coin_fit) begin
          reject_d = 1'b1;
        end else if (coin_any) begin
          if (sum >= PRICE_S) begin
            state_d  = DISPENSE;
            credit_d = CREDIT_W'(sum - PRICE_S);
          end else begin
            state_d  = ACCUM;
            credit_d = CREDIT_W'(sum);
          end
        end
        // A coin that completes the price takes priority over a same-cycle cancel
        if ((state == ACCUM) && cancel && (state_d != DISPENSE)) begin
          state_d = REFUND;
        end
      end
      DISPENSE: begin
        reject_d = coin_any;
        if (tc) begin
          if (credit != '0) begin
`ifdef VEND_CHANGE_EN
            state_d = CHANGE;
`else
            state_d = ACCUM;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      CHANGE, REFUND: begin
        reject_d = coin_any;
        if (credit == '0) begin
          state_d = IDLE;
        end else if (tick_in) begin
          change5_d = 1'b1;
          credit_d  = credit - 1'b1;
          if (credit == CREDIT_W'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      credit      <= '0;
      change5     <= 1'b0;
      coin_reject <= 1'b0;
      dispense    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      credit      <= credit_d;
      change5     <= change5_d;
      coin_reject <= reject_d;
      dispense    <= (state_d == DISPENSE);
      busy        <= (state_d == DISPENSE) || (state_d == CHANGE) || (state_d == REFUND);
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl with PRICE=3, CREDIT_W=4, PULSE_TICKS=4 and a tick every 10 cycles.
module tb_vend_ctrl;
  import vend_pkg::*;

  logic       clk_in  = 1'b0;
  logic       rst     = 1'b1;
  logic       tick_in = 1'b0;
  logic       coin5   = 1'b0;
  logic       coin10  = 1'b0;
  logic       cancel  = 1'b0;
  logic [3:0] credit;
  logic       dispense, change5, coin_reject, busy;

  int total = 0;
  int bad   = 0;
  int n_ticks;
  int n_pulses;

  always #5 clk_in = ~clk_in;

  vend_ctrl #(
    .PRICE       (3),
    .CREDIT_W    (4),
    .PULSE_TICKS (4)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .tick_in     (tick_in),
    .coin5       (coin5),
    .coin10      (coin10),
    .cancel      (cancel),
    .credit      (credit),
    .dispense    (dispense),
    .change5     (change5),
    .coin_reject (coin_reject),
    .busy        (busy)
  );

  initial begin : tick_gen
    int n;
    n = 0;
    forever begin
      @(posedge clk_in);
      #2;
      n++;
      tick_in = (n % 10 == 0);
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present inputs for one posedge, then leave them low; returns at the following negedge.
  task automatic drive(input logic c5, input logic c10, input logic can);
    coin5  = c5;
    coin10 = c10;
    cancel = can;
    @(negedge clk_in);
    coin5  = 1'b0;
    coin10 = 1'b0;
    cancel = 1'b0;
  endtask

  // Count ticks presented to the DUT while dispense is high; also watch for stray change5.
  task automatic wait_dispense(output int ticks);
    int stray;
    ticks = 0;
    stray = 0;
    for (int i = 0; i < 300; i++) begin
      if (!dispense) break;
      if (tick_in) ticks++;
      @(negedge clk_in);
      if (change5 && dispense) stray++;
    end
    if (dispense) chk("dispense_timeout", 32'(dispense), 0);
    chk("no_change5_during_dispense", stray, 0);
  endtask

  // Run until busy drops, counting change5 pulses and checking each follows a tick.
  task automatic wait_not_busy(output int pulses);
    logic prev_tick;
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      prev_tick = tick_in;
      @(negedge clk_in);
      if (change5) begin
        pulses++;
        chk("change5_after_tick", 32'(prev_tick), 1);
      end
    end
    if (busy) chk("busy_timeout", 32'(busy), 0);
  endtask

  initial begin : stim
    // Reset state
    repeat (3) @(negedge clk_in);
    chk("rst_credit", 32'(credit), 0);
    chk("rst_dispense", 32'(dispense), 0);
    chk("rst_change5", 32'(change5), 0);
    chk("rst_reject", 32'(coin_reject), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    @(negedge clk_in);

    // Exact price: coin10 then coin5
    drive(1'b0, 1'b1, 1'b0);
    chk("exact_credit2", 32'(credit), 2);
    chk("exact_state_accum", 32'(dut.state), 32'(ACCUM));
    chk("exact_not_busy", 32'(busy), 0);
    drive(1'b1, 1'b0, 1'b0);
    chk("exact_credit0", 32'(credit), 0);
    chk("exact_dispense", 32'(dispense), 1);
    chk("exact_busy", 32'(busy), 1);
    chk("exact_no_reject", 32'(coin_reject), 0);
    wait_dispense(n_ticks);
    chk("exact_ticks", n_ticks, 4);
    chk("exact_idle", 32'(dut.state), 32'(IDLE));
    chk("exact_idle_busy", 32'(busy), 0);
    chk("exact_idle_credit", 32'(credit), 0);

    // Overpay: coin10 twice
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    chk("over_dispense", 32'(dispense), 1);
    chk("over_credit1", 32'(credit), 1);
    wait_dispense(n_ticks);
    chk("over_ticks", n_ticks, 4);
`ifdef VEND_CHANGE_EN
    chk("over_state_change", 32'(dut.state), 32'(CHANGE));
    chk("over_change_busy", 32'(busy), 1);
    wait_not_busy(n_pulses);
    chk("over_change_pulses", n_pulses, 1);
    chk("over_final_credit", 32'(credit), 0);
    chk("over_final_idle", 32'(dut.state), 32'(IDLE));
`else
    chk("over_state_accum", 32'(dut.state), 32'(ACCUM));
    chk("over_keep_credit", 32'(credit), 1);
    chk("over_not_busy", 32'(busy), 0);
    drive(1'b0, 1'b0, 1'b1);
    chk("over_refund_state", 32'(dut.state), 32'(REFUND));
    wait_not_busy(n_pulses);
    chk("over_refund_pulses", n_pulses, 1);
    chk("over_refund_credit", 32'(credit), 0);
`endif

    // Cancel: coin5 then cancel
    drive(1'b1, 1'b0, 1'b0);
    chk("cancel_credit1", 32'(credit), 1);
    drive(1'b0, 1'b0, 1'b1);
    chk("cancel_state_refund", 32'(dut.state), 32'(REFUND));
    chk("cancel_busy", 32'(busy), 1);
    chk("cancel_no_dispense", 32'(dispense), 0);
    wait_not_busy(n_pulses);
    chk("cancel_pulses", n_pulses, 1);
    chk("cancel_credit0", 32'(credit), 0);
    chk("cancel_idle", 32'(dut.state), 32'(IDLE));

    // Cancel in IDLE has no effect, even across ticks
    drive(1'b0, 1'b0, 1'b1);
    n_pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (busy || change5 || credit != 4'd0) n_pulses++;
      @(negedge clk_in);
    end
    chk("idle_cancel_quiet", n_pulses, 0);
    chk("idle_cancel_state", 32'(dut.state), 32'(IDLE));

    // Reject: coin5 while dispensing
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    chk("rej_dispense", 32'(dispense), 1);
    drive(1'b1, 1'b0, 1'b0);
    chk("rej_pulse", 32'(coin_reject), 1);
    chk("rej_credit", 32'(credit), 0);
    @(negedge clk_in);
    chk("rej_pulse_end", 32'(coin_reject), 0);
    wait_dispense(n_ticks);
    chk("rej_idle", 32'(dut.state), 32'(IDLE));
    chk("rej_credit_after", 32'(credit), 0);

    // Simultaneous coins from IDLE: value 3 reaches the price directly
    drive(1'b1, 1'b1, 1'b0);
    chk("both_dispense", 32'(dispense), 1);
    chk("both_credit", 32'(credit), 0);
    chk("both_no_reject", 32'(coin_reject), 0);
    wait_dispense(n_ticks);
    chk("both_ticks", n_ticks, 4);
    chk("both_idle", 32'(dut.state), 32'(IDLE));

    // Collision: cancel with a coin that completes the price
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    chk("coll_state", 32'(dut.state), 32'(DISPENSE));
    chk("coll_dispense", 32'(dispense), 1);
    chk("coll_credit", 32'(credit), 0);
    n_pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      if (change5) n_pulses++;
    end
    chk("coll_no_refund", n_pulses, 0);
    chk("coll_still_disp", 32'(dispense), 1);

    // Asynchronous reset mid-dispense
    #2;
    rst = 1'b1;
    #1;
    chk("arst_dispense", 32'(dispense), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_credit", 32'(credit), 0);
    chk("arst_change5", 32'(change5), 0);
    chk("arst_reject", 32'(coin_reject), 0);
    chk("arst_state", 32'(dut.state), 32'(IDLE));
    @(negedge clk_in);
    rst = 1'b0;
    n_pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_in);
      if (busy || change5 || dispense) n_pulses++;
    end
    chk("post_rst_quiet", n_pulses, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
